// File: rtl/pool_pkg.sv
// Shared types, constants and the fp32 ordering key for the 2x2 max-pool stage.
package pool_pkg;

    localparam int FP_WIDTH = 32;

    localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_WIDTH-1:0] FP_NEG_INF  = 32'hFF80_0000;

    // Row phase of the pooling FSM; DROP swallows the unpaired last row of an odd-height frame.
    typedef enum logic [1:0] {
        ROW_EVEN = 2'd0,
        ROW_ODD  = 2'd1,
        DROP     = 2'd2
    } pool_phase_e;

    // Maps an fp32 bit pattern to an unsigned key whose order is the float order
    // (-0 below +0, negatives reversed, denormals in place, NaNs by bit pattern).
    function automatic logic [FP_WIDTH-1:0] fp_key(input logic [FP_WIDTH-1:0] x);
        return x[FP_WIDTH-1] ? ~x : (x | {1'b1, {(FP_WIDTH-1){1'b0}}});
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Valid-only pixel stream in, pooled pixel stream out.
interface maxpool2x2_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  valid_out;
    logic                  frame_last;

    // Producer / monitor side.
    modport master (
        output i_data, valid_in,
        input  o_data, valid_out, frame_last
    );

    // Pooling block side.
    modport slave (
        input  i_data, valid_in,
        output o_data, valid_out, frame_last
    );
endinterface

// File: rtl/fp32_max.sv
// Combinational fp32 maximum under the total bit-pattern order of fp_key.
module fp32_max
    import pool_pkg::*;
(
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    output logic [FP_WIDTH-1:0] y
);

    // b wins only when strictly greater, so equal keys return the first operand.
    assign y = (fp_key(b) > fp_key(a)) ? b : a;

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-ordered fp32 stream with no backpressure.
// Even rows leave horizontal pair maxima in a half-width line buffer; odd rows
// combine them with their own pair maxima and emit one pooled pixel per window.
module maxpool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = FP_WIDTH,
    parameter int WIDTH      = 30,
    parameter int HEIGHT     = 30
) (
    input logic                clk,
    input logic                rst,
    maxpool2x2_stream_if.slave strm
);

    localparam int COL_W    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LB_DEPTH = (WIDTH / 2 > 0) ? WIDTH / 2 : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_OUT_LAST = COL_W'(2 * (WIDTH / 2) - 1);
    localparam logic [ROW_W-1:0] ROW_OUT_LAST = ROW_W'(2 * (HEIGHT / 2) - 1);
    localparam bit               ODD_HEIGHT   = (HEIGHT % 2) == 1;

    pool_phase_e           state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q;
    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  valid_out_q;
    logic                  frame_last_q;

    logic [DATA_WIDTH-1:0] line_buf [LB_DEPTH];
    logic [LB_AW-1:0]      lb_idx;
    logic [DATA_WIDTH-1:0] lb_rd;
    logic [DATA_WIDTH-1:0] h_max;
    logic [DATA_WIDTH-1:0] v_max;

    // An odd final column maps past the buffer but is only ever read at odd columns.
    assign lb_idx = LB_AW'(col_q >> 1);
    assign lb_rd  = line_buf[lb_idx];

    fp32_max u_hmax (
        .a (pair_q),
        .b (strm.i_data),
        .y (h_max)
    );

    fp32_max u_vmax (
        .a (lb_rd),
        .b (h_max),
        .y (v_max)
    );

    // Next column, row and row phase; everything holds unless a pixel is accepted.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (strm.valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = ROW_EVEN;
                end else begin
                    row_d = row_q + ROW_W'(1);
                    if (ODD_HEIGHT && (row_d == ROW_LAST)) begin
                        state_d = DROP;
                    end else if (state_q == ROW_EVEN) begin
                        state_d = ROW_ODD;
                    end else begin
                        state_d = ROW_EVEN;
                    end
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Counters, phase, pair register and the registered pooled output.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= ROW_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= FP_POS_ZERO;
            o_data_q     <= FP_POS_ZERO;
            valid_out_q  <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            valid_out_q  <= 1'b0;
            frame_last_q <= 1'b0;
            if (strm.valid_in) begin
                if (!col_q[0]) begin
                    pair_q <= strm.i_data;
                end else if (state_q == ROW_ODD) begin
                    o_data_q     <= v_max;
                    valid_out_q  <= 1'b1;
                    frame_last_q <= (row_q == ROW_OUT_LAST) && (col_q == COL_OUT_LAST);
                end
            end
        end
    end

    // Even rows park each horizontal pair maximum for the row below.
    always_ff @(posedge clk) begin
        // NOTE: the line buffer has no reset; every entry is written in an even row before it is read.
        if (!rst && strm.valid_in && col_q[0] && (state_q == ROW_EVEN)) begin
            line_buf[lb_idx] <= h_max;
        end
    end

    assign strm.o_data     = o_data_q;
    assign strm.valid_out  = valid_out_q;
    assign strm.frame_last = frame_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: 4x4, 5x5 and 30x30 instances
// driven from one stimulus bus, checked against a window-level reference model.
module tb_maxpool2x2_stream;
    import pool_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] drv_data  = '0;
    logic        drv_valid = 1'b0;
    int          drv_sel   = 0;

    maxpool2x2_stream_if #(.DATA_WIDTH(32)) if4  ();
    maxpool2x2_stream_if #(.DATA_WIDTH(32)) if5  ();
    maxpool2x2_stream_if #(.DATA_WIDTH(32)) if30 ();

    assign if4.i_data   = drv_data;
    assign if5.i_data   = drv_data;
    assign if30.i_data  = drv_data;
    assign if4.valid_in  = drv_valid && (drv_sel == 4);
    assign if5.valid_in  = drv_valid && (drv_sel == 5);
    assign if30.valid_in = drv_valid && (drv_sel == 30);

    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4),  .HEIGHT(4))  dut4  (.clk(clk), .rst(rst), .strm(if4.slave));
    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(5),  .HEIGHT(5))  dut5  (.clk(clk), .rst(rst), .strm(if5.slave));
    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(30), .HEIGHT(30)) dut30 (.clk(clk), .rst(rst), .strm(if30.slave));

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        last;
        int          cyc;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    logic [31:0] pix [0:1799];
    int          acc [0:1799];

    // Record every output pulse (or stray frame_last) with the cycle it was seen.
    always @(negedge clk) begin
        if (if4.valid_out  || if4.frame_last)  obs_q.push_back('{4,  if4.o_data,  if4.frame_last,  cyc});
        if (if5.valid_out  || if5.frame_last)  obs_q.push_back('{5,  if5.o_data,  if5.frame_last,  cyc});
        if (if30.valid_out || if30.frame_last) obs_q.push_back('{30, if30.o_data, if30.frame_last, cyc});
    end

    // Small positive integer to fp32 bits.
    function automatic logic [31:0] int_fp(input int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    // Float order as a total order on bit patterns.
    function automatic logic [31:0] ref_key(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    function automatic logic [31:0] ref_max4(input logic [31:0] a, b, c, d);
        logic [31:0] v [4];
        logic [31:0] best;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        best = v[0];
        for (int k = 1; k < 4; k++) if (ref_key(v[k]) > ref_key(best)) best = v[k];
        return best;
    endfunction

    // Stream pix[0..n-1] into one instance, with gap idle cycles before each pixel.
    task automatic send(input int id, input int n, input int gap);
        drv_sel = id;
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin
                @(negedge clk);
                drv_valid = 1'b0;
            end
            @(negedge clk);
            drv_valid = 1'b1;
            drv_data  = pix[i];
            acc[i]    = cyc + 1;
        end
        @(negedge clk);
        drv_valid = 1'b0;
    endtask

    // Every 2x2 window whose four pixels were sent, in raster order, due the cycle after its 4th pixel.
    task automatic build_expected(input int id, input int w, input int h, input int n);
        for (int f = 0; f * w * h < n; f++) begin
            for (int r = 0; r < h / 2; r++) begin
                for (int c = 0; c < w / 2; c++) begin
                    int i00 = f * w * h + 2 * r * w + 2 * c;
                    int i11 = i00 + w + 1;
                    if (i11 < n) begin
                        exp_q.push_back('{id, ref_max4(pix[i00], pix[i00 + 1], pix[i00 + w], pix[i11]),
                                          (r == h / 2 - 1) && (c == w / 2 - 1), acc[i11]});
                    end
                end
            end
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        drv_sel   = 4;
        drv_valid = 1'b1;
        drv_data  = 32'h4120_0000;
        repeat (3) @(negedge clk);
        n_checks += 3;
        if (if4.o_data !== 32'h0 || if4.valid_out !== 1'b0 || if4.frame_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut4: got o_data=%h valid_out=%b frame_last=%b want 0/0/0", if4.o_data, if4.valid_out, if4.frame_last);
        end
        if (if5.o_data !== 32'h0 || if5.valid_out !== 1'b0 || if5.frame_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut5: got o_data=%h valid_out=%b frame_last=%b want 0/0/0", if5.o_data, if5.valid_out, if5.frame_last);
        end
        if (if30.o_data !== 32'h0 || if30.valid_out !== 1'b0 || if30.frame_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut30: got o_data=%h valid_out=%b frame_last=%b want 0/0/0", if30.o_data, if30.valid_out, if30.frame_last);
        end
        rst       = 1'b0;
        drv_valid = 1'b0;
        settle();
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: got %0d output pulses want 0", obs_q.size());
        end
    endtask

    task automatic test_frame4();
        logic [31:0] want [4];
        want[0] = 32'h40C0_0000; want[1] = 32'h4100_0000; want[2] = 32'h4160_0000; want[3] = 32'h4180_0000;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix[i] = int_fp(i + 1);
        send(4, 16, 0);
        build_expected(4, 4, 4, 16);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL frame4_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].id != exp_q[k].id || obs_q[k].data !== want[k] || obs_q[k].last !== exp_q[k].last || obs_q[k].cyc != exp_q[k].cyc) begin
                n_fail++;
                $display("FAIL frame4_out[%0d]: got dut%0d %h last=%b cyc=%0d want dut%0d %h last=%b cyc=%0d", k,
                         obs_q[k].id, obs_q[k].data, obs_q[k].last, obs_q[k].cyc, exp_q[k].id, want[k], exp_q[k].last, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_neg_zero();
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix[i] = $urandom;
        pix[0] = 32'hC000_0000; pix[1] = 32'hBF80_0000; pix[4] = 32'h8000_0000; pix[5] = 32'hC040_0000;
        pix[2] = 32'h8000_0000; pix[3] = FP_POS_ZERO;   pix[6] = 32'hBF80_0000; pix[7] = 32'hC000_0000;
        pix[8] = FP_NEG_INF;
        send(4, 16, 0);
        build_expected(4, 4, 4, 16);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL negzero_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            n_checks += 2;
            if (obs_q[0].data !== 32'h8000_0000) begin
                n_fail++;
                $display("FAIL negzero_win0: got %h want 80000000", obs_q[0].data);
            end
            if (obs_q[1].data !== 32'h0000_0000) begin
                n_fail++;
                $display("FAIL negzero_win1: got %h want 00000000", obs_q[1].data);
            end
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].id != exp_q[k].id || obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last || obs_q[k].cyc != exp_q[k].cyc) begin
                n_fail++;
                $display("FAIL negzero_out[%0d]: got dut%0d %h last=%b cyc=%0d want dut%0d %h last=%b cyc=%0d", k,
                         obs_q[k].id, obs_q[k].data, obs_q[k].last, obs_q[k].cyc, exp_q[k].id, exp_q[k].data, exp_q[k].last, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_odd_dims();
        int want [8];
        want = '{7, 9, 17, 19, 7, 9, 17, 19};
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 50; i++) pix[i] = int_fp(i % 25 + 1);
        send(5, 50, 0);
        build_expected(5, 5, 5, 50);
        settle();
        n_checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            n_fail++;
            $display("FAIL odd_count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].id != exp_q[k].id || obs_q[k].data !== int_fp(want[k]) || obs_q[k].data !== exp_q[k].data ||
                obs_q[k].last !== exp_q[k].last || obs_q[k].cyc != exp_q[k].cyc) begin
                n_fail++;
                $display("FAIL odd_out[%0d]: got dut%0d %h last=%b cyc=%0d want dut%0d %h last=%b cyc=%0d", k,
                         obs_q[k].id, obs_q[k].data, obs_q[k].last, obs_q[k].cyc, exp_q[k].id, int_fp(want[k]), exp_q[k].last, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_gapped();
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix[i] = int_fp(i + 1);
        send(4, 16, 2);
        build_expected(4, 4, 4, 16);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL gapped_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].id != exp_q[k].id || obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last || obs_q[k].cyc != exp_q[k].cyc) begin
                n_fail++;
                $display("FAIL gapped_out[%0d]: got dut%0d %h last=%b cyc=%0d want dut%0d %h last=%b cyc=%0d", k,
                         obs_q[k].id, obs_q[k].data, obs_q[k].last, obs_q[k].cyc, exp_q[k].id, exp_q[k].data, exp_q[k].last, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix[i] = int_fp(i + 1);
        // Pixels 1..7 complete only the first window; pixel 7 is left dangling.
        send(4, 7, 0);
        build_expected(4, 4, 4, 7);
        @(negedge clk);
        rst       = 1'b1;
        drv_valid = 1'b1;
        drv_data  = 32'h7F7F_FFFF;
        @(negedge clk);
        rst       = 1'b0;
        drv_valid = 1'b0;
        send(4, 16, 0);
        build_expected(4, 4, 4, 16);
        settle();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].id != exp_q[k].id || obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last || obs_q[k].cyc != exp_q[k].cyc) begin
                n_fail++;
                $display("FAIL midrst_out[%0d]: got dut%0d %h last=%b cyc=%0d want dut%0d %h last=%b cyc=%0d", k,
                         obs_q[k].id, obs_q[k].data, obs_q[k].last, obs_q[k].cyc, exp_q[k].id, exp_q[k].data, exp_q[k].last, exp_q[k].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_last = 0;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 1800; i++) pix[i] = $urandom;
        send(30, 1800, 0);
        build_expected(30, 30, 30, 1800);
        settle();
        n_checks++;
        if (obs_q.size() != 450 || exp_q.size() != 450) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 450 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].last === 1'b1) n_last++;
            if (obs_q[k].id != exp_q[k].id || obs_q[k].data !== exp_q[k].data || obs_q[k].last !== exp_q[k].last || obs_q[k].cyc != exp_q[k].cyc) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got dut%0d %h last=%b cyc=%0d want dut%0d %h last=%b cyc=%0d", k,
                         obs_q[k].id, obs_q[k].data, obs_q[k].last, obs_q[k].cyc, exp_q[k].id, exp_q[k].data, exp_q[k].last, exp_q[k].cyc);
            end
        end
        n_checks++;
        if (n_last != 2 || obs_q.size() < 450 || obs_q[224].last !== 1'b1 || obs_q[449].last !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_frame_last: got %0d pulses want 2 at outputs 225 and 450", n_last);
        end
    endtask

    initial begin
        test_reset();
        test_frame4();
        test_neg_zero();
        test_odd_dims();
        test_gapped();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
